axi_tile_rd_seq: RTL

Request sequencer directly upstream of the AXI read adapter. It accepts one tile-load command: base address, row count, beats per row and row stride. It splits the tile into INCR read bursts of at most 64 beats that never cross a 4 KB boundary, and drives the adapter's request port one burst at a time. It tracks returned beats to detect end of burst and end of tile, then reports completion and beat-count errors to the tensor core controller.

---
 rtl/axi_tile_rd_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/axi_tile_rd_seq.sv
// Tile-load request sequencer for the AXI read adapter.
// Splits a strided 2-D tile into INCR bursts of at most 64 beats that never
// cross a 4 KB page, issues them one at a time, counts returned beats and
// reports tile completion together with a beat-count error flag.
module axi_tile_rd_seq #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_base,
  input  logic [15:0]           cmd_rows,
  input  logic [11:0]           cmd_row_beats,
  input  logic [ADDR_WIDTH-1:0] cmd_stride,
  input  logic [2:0]            cmd_sel,
  output logic [31:0]           axi_out_BASE,
  output logic [5:0]            axi_out_burst_num,
  output logic [2:0]            axi_out_burst_size,
  output logic                  axi_out_request_valid,
  output logic [2:0]            axi_out_sel,
  input  logic                  axi_in_arready,
  input  logic                  axi_in_valid,
  input  logic                  axi_in_finish,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [27:0]           beat_total
);

  localparam int BEAT_BYTES = DATA_WIDTH / 8;
  localparam int SIZE_LOG2  = $clog2(BEAT_BYTES);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_REQ  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] row_base;
  logic [ADDR_WIDTH-1:0] stride;
  logic [11:0]           row_beats;
  logic [11:0]           row_left;
  logic [15:0]           rows_left;
  logic [6:0]            exp_beats;
  logic [12:0]           burst_cnt;

  logic [12:0]           page_left;
  logic [12:0]           beats_full;
  logic [6:0]            beats;
  logic [ADDR_WIDTH-1:0] addr_adv;
  logic [ADDR_WIDTH-1:0] next_row;
  logic [11:0]           row_left_dec;
  logic [12:0]           cnt_inc;

  // Burst length: remaining row beats, clipped to 64 and to the end of the 4 KB page.
  always_comb begin
    page_left  = (13'd4096 - {1'b0, addr[11:0]}) >> SIZE_LOG2;
    beats_full = {1'b0, row_left};
    if (beats_full > 13'd64)
      beats_full = 13'd64;
    if (beats_full > page_left)
      beats_full = page_left;
  end

  assign beats        = 7'(beats_full);
  assign addr_adv     = addr + (ADDR_WIDTH'(exp_beats) << SIZE_LOG2);
  assign next_row     = row_base + stride;
  assign row_left_dec = row_left - {5'b0, exp_beats};
  assign cnt_inc      = burst_cnt + 13'd1;

  // cmd_ready is forced low while reset is held so nothing is accepted during reset.
  assign cmd_ready             = aresetn && (state == S_IDLE);
  assign axi_out_request_valid = (state == S_REQ);
  assign busy                  = (state != S_IDLE);
  assign done                  = (state == S_DONE);
  assign axi_out_burst_size    = 3'(SIZE_LOG2);

  // Sequencer FSM: command latch, burst planning, request handshake and beat tracking.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state             <= S_IDLE;
      addr              <= '0;
      row_base          <= '0;
      stride            <= '0;
      row_beats         <= '0;
      row_left          <= '0;
      rows_left         <= '0;
      exp_beats         <= '0;
      burst_cnt         <= '0;
      axi_out_BASE      <= '0;
      axi_out_burst_num <= '0;
      axi_out_sel       <= '0;
      err               <= 1'b0;
      beat_total        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            addr        <= cmd_base;
            row_base    <= cmd_base;
            stride      <= cmd_stride;
            row_beats   <= cmd_row_beats;
            row_left    <= cmd_row_beats;
            rows_left   <= cmd_rows;
            axi_out_sel <= cmd_sel;
            beat_total  <= '0;
            if (cmd_rows == 16'd0 || cmd_row_beats == 12'd0) begin
              err   <= 1'b1;
              state <= S_DONE;
            end else begin
              err   <= 1'b0;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          axi_out_BASE      <= 32'(addr);
          axi_out_burst_num <= 6'(beats - 7'd1);
          exp_beats         <= beats;
          burst_cnt         <= '0;
          state             <= S_REQ;
        end
        S_REQ: begin
          if (axi_in_arready)
            state <= S_DATA;
        end
        S_DATA: begin
          if (axi_in_valid) begin
            beat_total <= beat_total + 28'd1;
            burst_cnt  <= cnt_inc;
            if (axi_in_finish) begin
              if (cnt_inc != {6'b0, exp_beats})
                err <= 1'b1;
              // Row bookkeeping follows the planned burst length, not the observed one.
              if (row_left_dec == 12'd0) begin
                row_base  <= next_row;
                addr      <= next_row;
                row_left  <= row_beats;
                rows_left <= rows_left - 16'd1;
                state     <= (rows_left == 16'd1) ? S_DONE : S_CALC;
              end else begin
                addr     <= addr_adv;
                row_left <= row_left_dec;
                state    <= S_CALC;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
